tmu_collect: RTL
================

TMU_COLLECT -- requirements
Module: tmu_collect

Interface
REQ-001 The module SHALL provide parameter WIDTH, default 12, giving the result data width in bits.
REQ-002 The module SHALL provide parameter DEPTH, default 4, giving the entries per channel FIFO; the value SHALL be a power of two.
REQ-003 The module SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL provide port rstn, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL provide port pid_valid, input, 1 bit: the PID result-write strobe.
REQ-006 The module SHALL provide port pid_data, input, WIDTH bits: the PID result word.
REQ-007 The module SHALL provide port cordic_valid, input, 1 bit: the CORDIC result-write strobe.
REQ-008 The module SHALL provide port cordic_data, input, WIDTH bits: the CORDIC result word.
REQ-009 The module SHALL provide port read_enable, input, 1 bit: the pop request from the reader.
REQ-010 The module SHALL provide port read_sel, input, 1 bit: channel select, 0=PID, 1=CORDIC.
REQ-011 The module SHALL provide port err_clr, input, 1 bit: clears the sticky error flags.
REQ-012 The module SHALL provide port data_out, output, WIDTH bits: the popped result word.
REQ-013 The module SHALL provide port data_valid, output, 1 bit: a one-cycle pulse marking data_out as new.
REQ-014 The module SHALL provide port pid_count, output, 3 bits: PID FIFO occupancy, 0..DEPTH.
REQ-015 The module SHALL provide port cordic_count, output, 3 bits: CORDIC FIFO occupancy, 0..DEPTH.
REQ-016 The module SHALL provide port overflow, output, 2 bits: sticky flags, [0]=PID, [1]=CORDIC.
REQ-017 The module SHALL provide port underflow, output, 2 bits: sticky flags, [0]=PID, [1]=CORDIC.

Function
REQ-018 Each channel SHALL be an independent DEPTH-entry FIFO with a write pointer, a read pointer and an occupancy counter; both pointers SHALL wrap modulo DEPTH.
REQ-019 A push SHALL occur when the channel's valid is 1 and the channel's count is below DEPTH at the start of the cycle; the word is written at the write pointer.
REQ-020 When valid is 1, count equals DEPTH and no same-cycle pop occurs, the word SHALL be dropped and the channel's overflow bit set.
REQ-021 A pop SHALL occur when read_enable is 1, read_sel selects the channel, and that channel's count is above 0 at the start of the cycle.
REQ-022 On a pop, data_out SHALL take the word at the read pointer and data_valid SHALL be 1 on the next cycle (latency 1).
REQ-023 read_enable with the selected count equal to 0 SHALL set that channel's underflow bit, leave data_out unchanged and keep data_valid at 0.
REQ-024 data_valid SHALL be 0 in every cycle not following a pop; data_out SHALL hold its last popped value.
REQ-025 A simultaneous push and pop on a full channel SHALL both succeed, with count unchanged and no overflow.
REQ-026 A simultaneous push and pop on an empty channel SHALL perform the push only, set underflow, and leave count at 1.
REQ-027 A push on one channel and a pop on the other in the same cycle SHALL both proceed independently.
REQ-028 err_clr=1 SHALL clear all overflow and underflow bits; if a new error event occurs in the same cycle, that bit SHALL be set.
REQ-029 Each count SHALL equal the previous count plus pushes minus pops; it SHALL never exceed DEPTH or go below 0.
REQ-030 FIFO storage SHALL not be reset; only pointers, counts, flags, data_out and data_valid are reset.

Reset
REQ-031 While rstn=0 at a rising edge, the next state SHALL be: pointers 0, pid_count 0, cordic_count 0, overflow 2'b00, underflow 2'b00, data_out 0, data_valid 0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered words and override same-cycle push, pop and err_clr.
REQ-033 The first push SHALL be accepted on the first edge with rstn=1.

Verification
REQ-034 The bench SHALL cover: push PID 0x123, 0x456, then pop PID twice -> data_out 0x123 then 0x456, each with a one-cycle data_valid, pid_count 2->1->0.
REQ-035 The bench SHALL cover: 5 CORDIC pushes 0x001..0x005 with no pops -> cordic_count 4, overflow=2'b10, pops return 0x001..0x004.
REQ-036 The bench SHALL cover: a full PID FIFO with push 0x7FF and pop in the same cycle -> oldest word out, count stays 4, overflow[0] stays 0.
REQ-037 The bench SHALL cover: a pop on empty CORDIC -> underflow=2'b10, data_valid 0; then err_clr -> underflow=2'b00.
REQ-038 The bench SHALL cover: 6 push/pop pairs on PID (pointer wrap) -> data returned in order 0x010..0x015, count ends at 0.
REQ-039 The bench SHALL cover: 3 words in each FIFO, then rstn=0 for one cycle -> counts 0, data_valid 0, a following pop sets underflow.

Source files
------------

// File: rtl/tmu_collect.sv
// tmu_collect: gathers result words from the PID and CORDIC engines into two
// independent FIFOs. A single reader pops them one at a time through a
// shared registered output. Overflow and underflow events are recorded in
// sticky flags for each channel.

module tmu_collect #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pid_valid,
  input  logic [WIDTH-1:0] pid_data,
  input  logic             cordic_valid,
  input  logic [WIDTH-1:0] cordic_data,
  input  logic             read_enable,
  input  logic             read_sel,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [2:0]       pid_count,
  output logic [2:0]       cordic_count,
  output logic [1:0]       overflow,
  output logic [1:0]       underflow
);

  // DEPTH is a power of two, so the pointers wrap for free at PW bits.
  localparam int         PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] FULL = 3'(DEPTH);

  // Index 0 is the PID channel and index 1 is the CORDIC channel throughout.
  logic [WIDTH-1:0] r_mem [2][DEPTH];
  logic [PW-1:0]    r_wrPtr [2];
  logic [PW-1:0]    r_rdPtr [2];
  logic [2:0]       r_count [2];
  logic [1:0]       r_overflow;
  logic [1:0]       r_underflow;
  logic [WIDTH-1:0] r_dataOut;
  logic             r_dataValid;

  logic [WIDTH-1:0] w_data [2];
  logic [1:0]       w_valid;
  logic [1:0]       w_selHit;
  logic [1:0]       w_empty;
  logic [1:0]       w_full;
  logic [1:0]       w_pop;
  logic [1:0]       w_push;
  logic [1:0]       w_ovfSet;
  logic [1:0]       w_udfSet;
  logic [WIDTH-1:0] w_popData;

  assign w_data[0] = pid_data;
  assign w_data[1] = cordic_data;
  assign w_valid   = {cordic_valid, pid_valid};
  assign w_selHit  = {read_enable & read_sel, read_enable & ~read_sel};

  // Decide pushes, pops and error events from the occupancy at the start of the cycle.
  // A pop on a full channel frees the slot that the same-cycle push writes.
  // This lets both succeed.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_empty[c] = (r_count[c] == 3'd0);
      w_full[c]  = (r_count[c] == FULL);
    end
    w_pop     = w_selHit & ~w_empty;
    w_push    = w_valid & (~w_full | w_pop);
    w_ovfSet  = w_valid & w_full & ~w_pop;
    w_udfSet  = w_selHit & w_empty;
    w_popData = read_sel ? r_mem[1][r_rdPtr[1]] : r_mem[0][r_rdPtr[0]];
  end

  // FIFO storage is written on a push and is intentionally never reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (w_push[c]) begin
        r_mem[c][r_wrPtr[c]] <= w_data[c];
      end
    end
  end

  // Update the pointers and occupancy. Reset discards every buffered word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int c = 0; c < 2; c++) begin
        r_wrPtr[c] <= '0;
        r_rdPtr[c] <= '0;
        r_count[c] <= 3'd0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_push[c]) begin
          r_wrPtr[c] <= r_wrPtr[c] + PW'(1);
        end
        if (w_pop[c]) begin
          r_rdPtr[c] <= r_rdPtr[c] + PW'(1);
        end
        r_count[c] <= r_count[c] + 3'(w_push[c]) - 3'(w_pop[c]);
      end
    end
  end

  // Sticky error flags. A new event in the same cycle as err_clr still sets its bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overflow  <= 2'b00;
      r_underflow <= 2'b00;
    end else begin
      r_overflow  <= (r_overflow  & ~{2{err_clr}}) | w_ovfSet;
      r_underflow <= (r_underflow & ~{2{err_clr}}) | w_udfSet;
    end
  end

  // Register the popped word and pulse data_valid for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
    end else begin
      r_dataValid <= |w_pop;
      if (|w_pop) begin
        r_dataOut <= w_popData;
      end
    end
  end

  assign data_out     = r_dataOut;
  assign data_valid   = r_dataValid;
  assign pid_count    = r_count[0];
  assign cordic_count = r_count[1];
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
